alu_output_pipe: RTL and testbench

Parametrised, registered successor to the CPU's ALU output stage. Adds the shift-unit and logic-unit operands with a selectable carry-in, registers the result and the five status flags, and drives the result onto the main bus on request. Also holds a small flag stack, so interrupt entry and exit can save and restore flags without using the bus.

---
 rtl/alu_output_pipe.sv | 163 ++++++++++++++++
 tb/tb_alu_output_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_output_pipe.sv
// ---------------------------------------------------------------------------
// alu_output_pipe
//   Registered ALU output stage. Adds the shift-unit and logic-unit operands
//   with a selectable carry-in. It registers the sum and five status flags,
//   and drives the result onto the main bus on request. A small LIFO of
//   saved flag sets lets interrupt entry/exit preserve flags off-bus.
//
// Ports
//   AluClock, Reset            clock, async active-high reset
//   Shift, Logic               operands A / B (WIDTH)
//   CarrySel                   cin: 0->0, 1->CarryA, 2->1, 3->CarryL
//   LCarryNew                  carry from logic/shift unit (becomes CarryL)
//   InValid, UpdateFlags       capture op / also load flags
//   FlagsPush, FlagsPop        flag stack control (pop wins over push)
//   Alu_Assert                 drive result onto MainBus, else Z
//   MainBus                    tri-state result bus (WIDTH)
//   ResultValid                result register holds a captured op
//   Flags_*                    flag register bits
//   StackDepth                 occupied stack entries
//   StackOverflow/Underflow    sticky stack error bits
// ---------------------------------------------------------------------------
module alu_output_pipe #(
   parameter int WIDTH            = 8,
   parameter int FLAG_STACK_DEPTH = 4,
   localparam int SDW = $clog2(FLAG_STACK_DEPTH + 1)
) (
   input  logic             AluClock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Shift,
   input  logic [WIDTH-1:0] Logic,
   input  logic [1:0]       CarrySel,
   input  logic             LCarryNew,
   input  logic             InValid,
   input  logic             UpdateFlags,
   input  logic             FlagsPush,
   input  logic             FlagsPop,
   input  logic             Alu_Assert,
   output logic [WIDTH-1:0] MainBus,
   output logic             ResultValid,
   output logic             Flags_0_Overflow,
   output logic             Flags_1_Sign,
   output logic             Flags_2_Zero,
   output logic             Flags_3_CarryA,
   output logic             Flags_4_CarryL,
   output logic [SDW-1:0]   StackDepth,
   output logic             StackOverflow,
   output logic             StackUnderflow
);

   localparam int IW = (FLAG_STACK_DEPTH > 1) ? $clog2(FLAG_STACK_DEPTH) : 1;
   localparam logic [SDW-1:0] DEPTH_MAX = SDW'(FLAG_STACK_DEPTH);

   // Flag vector bit order: {CarryL, CarryA, Zero, Sign, Overflow}
   logic [WIDTH-1:0] result_q, result_d;
   logic             valid_q, valid_d;
   logic [4:0]       flags_q, flags_d;
   logic [SDW-1:0]   depth_q, depth_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [4:0]       stack_q [FLAG_STACK_DEPTH];

   logic             cin;
   logic             cout;
   logic [WIDTH-1:0] sum;
   logic [4:0]       op_flags;
   logic             st_full, st_empty;
   logic             do_push, do_pop;
   logic [IW-1:0]    top_idx, push_idx;

   // Carry-in always reads the flags as they stand before this edge, so
   // back-to-back ops chain through the registered carries.
   always_comb begin
      cin = 1'b0;
      case (CarrySel)
         2'd0: cin = 1'b0;
         2'd1: cin = flags_q[3];
         2'd2: cin = 1'b1;
         2'd3: cin = flags_q[4];
         default: cin = 1'b0;
      endcase
   end

   assign {cout, sum} = {1'b0, Shift} + {1'b0, Logic} + {{WIDTH{1'b0}}, cin};

   assign op_flags = {LCarryNew,
                      cout,
                      (sum == '0),
                      sum[WIDTH-1],
                      (Shift[WIDTH-1] == Logic[WIDTH-1]) && (sum[WIDTH-1] != Shift[WIDTH-1])};

   assign st_full  = (depth_q == DEPTH_MAX);
   assign st_empty = (depth_q == '0);
   assign top_idx  = IW'(depth_q - SDW'(1));
   assign push_idx = IW'(depth_q);

   // A simultaneous push is dropped silently when pop is asserted.
   assign do_pop  = FlagsPop && !st_empty;
   assign do_push = FlagsPush && !FlagsPop && !st_full;

   always_comb begin
      result_d = result_q;
      valid_d  = valid_q;
      flags_d  = flags_q;
      depth_d  = depth_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;

      if (InValid) begin
         result_d = sum;
         valid_d  = 1'b1;
         if (UpdateFlags) flags_d = op_flags;
      end

      // Pop overrides any flag update from the operation.
      if (FlagsPop) begin
         if (st_empty) unf_d = 1'b1;
         else begin
            flags_d = stack_q[top_idx];
            depth_d = depth_q - SDW'(1);
         end
      end else if (FlagsPush) begin
         if (st_full) ovf_d = 1'b1;
         else         depth_d = depth_q + SDW'(1);
      end
   end

   always_ff @(posedge AluClock or posedge Reset) begin
      if (Reset) begin
         result_q <= '0;
         valid_q  <= 1'b0;
         flags_q  <= '0;
         depth_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         result_q <= result_d;
         valid_q  <= valid_d;
         flags_q  <= flags_d;
         depth_q  <= depth_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Stack contents need no reset; only depth qualifies them. Writes are
   // still blocked while Reset is high so an aborted cycle leaves no trace.
   // The pushed value is the pre-edge flag register.
   always_ff @(posedge AluClock) begin
      if (!Reset && do_push) stack_q[push_idx] <= flags_q;
   end

   assign MainBus          = Alu_Assert ? result_q : {WIDTH{1'bz}};
   assign ResultValid      = valid_q;
   assign Flags_0_Overflow = flags_q[0];
   assign Flags_1_Sign     = flags_q[1];
   assign Flags_2_Zero     = flags_q[2];
   assign Flags_3_CarryA   = flags_q[3];
   assign Flags_4_CarryL   = flags_q[4];
   assign StackDepth       = depth_q;
   assign StackOverflow    = ovf_q;
   assign StackUnderflow   = unf_q;

endmodule

// File: tb/tb_alu_output_pipe.sv
module tb_alu_output_pipe;
   localparam int W = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] shf, lgc;
   logic [1:0]   csel;
   logic         lcn, iv, uf, push, pop, aa;
   wire  [W-1:0] bus;
   logic         rv, f0, f1, f2, f3, f4, sovf, sunf;
   logic [2:0]   sdep;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_output_pipe #(.WIDTH(W), .FLAG_STACK_DEPTH(D)) dut (
      .AluClock(clk), .Reset(rst), .Shift(shf), .Logic(lgc), .CarrySel(csel),
      .LCarryNew(lcn), .InValid(iv), .UpdateFlags(uf), .FlagsPush(push),
      .FlagsPop(pop), .Alu_Assert(aa), .MainBus(bus), .ResultValid(rv),
      .Flags_0_Overflow(f0), .Flags_1_Sign(f1), .Flags_2_Zero(f2),
      .Flags_3_CarryA(f3), .Flags_4_CarryL(f4), .StackDepth(sdep),
      .StackOverflow(sovf), .StackUnderflow(sunf));

   typedef struct packed {
      logic [W-1:0] bus;
      logic [4:0]   flags;
      logic [2:0]   depth;
      logic         ovf, unf, valid;
   } exp_t;

   exp_t       sbq[$];
   logic [W-1:0] m_res;
   logic       m_valid, m_ovf, m_unf;
   logic [4:0] m_flags;
   logic [4:0] m_stk[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_res = '0; m_valid = 0; m_ovf = 0; m_unf = 0; m_flags = '0;
      m_stk.delete();
   endtask

   task automatic idle_inputs();
      shf = '0; lgc = '0; csel = 0; lcn = 0; iv = 0; uf = 0; push = 0; pop = 0;
   endtask

   // Drive one cycle of stimulus, push the model's expectation, clock, then
   // pop the scoreboard and compare against the DUT.
   task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [1:0] cs, input logic lc, input logic v,
                     input logic u, input logic ps, input logic pp);
      logic       c;
      logic [8:0] full;
      logic [4:0] nf, old;
      exp_t       e, got;
      shf = a; lgc = b; csel = cs; lcn = lc; iv = v; uf = u; push = ps; pop = pp;
      case (cs)
         2'd0: c = 1'b0;
         2'd1: c = m_flags[3];
         2'd2: c = 1'b1;
         default: c = m_flags[4];
      endcase
      full = {1'b0, a} + {1'b0, b} + {8'h00, c};
      nf = {lc, full[8], full[7:0] == 8'h00, full[7], (a[7] == b[7]) && (full[7] != a[7])};
      old = m_flags;
      if (v) begin
         m_res = full[7:0]; m_valid = 1;
         if (u) m_flags = nf;
      end
      if (pp) begin
         if (m_stk.size() == 0) m_unf = 1;
         else m_flags = m_stk.pop_back();
      end else if (ps) begin
         if (m_stk.size() == D) m_ovf = 1;
         else m_stk.push_back(old);
      end
      e.bus = m_res; e.flags = m_flags; e.depth = 3'(m_stk.size());
      e.ovf = m_ovf; e.unf = m_unf; e.valid = m_valid;
      sbq.push_back(e);
      @(posedge clk); #1;
      idle_inputs();
      got = sbq.pop_front();
      chk({tag, ".bus"},   {24'h0, bus},  {24'h0, got.bus});
      chk({tag, ".flags"}, {27'h0, f4, f3, f2, f1, f0}, {27'h0, got.flags});
      chk({tag, ".depth"}, {29'h0, sdep}, {29'h0, got.depth});
      chk({tag, ".err"},   {30'h0, sovf, sunf}, {30'h0, got.ovf, got.unf});
      chk({tag, ".valid"}, {31'h0, rv}, {31'h0, got.valid});
   endtask

   task automatic do_reset();
      rst = 1; idle_inputs();
      repeat (2) @(posedge clk);
      #2 rst = 0;
      model_reset();
   endtask

   logic [31:0] zexp;

   initial begin
      zexp = {24'h0, {8{1'bz}}};
      aa = 0;
      model_reset();
      do_reset();
      #1;
      // Reset state, bus released then asserted
      chk("rst.busZ",  {24'h0, bus}, zexp);
      chk("rst.flags", {27'h0, f4, f3, f2, f1, f0}, 32'h0);
      chk("rst.depth", {29'h0, sdep}, 32'h0);
      chk("rst.valid", {31'h0, rv}, 32'h0);
      aa = 1; #1;
      chk("rst.bus0",  {24'h0, bus}, 32'h0);

      // Arithmetic directed cases
      op("ff+01",  8'hFF, 8'h01, 2'd0, 0, 1, 1, 0, 0);
      chk("ff+01.const", {24'h0, bus, 3'b0, f4, f3, f2, f1, f0}, {24'h0, 8'h00, 8'b0000_1100} >> 0 & 32'hFFFF);
      op("cinA",   8'h00, 8'h00, 2'd1, 0, 1, 1, 0, 0);
      chk("cinA.const", {24'h0, bus}, 32'h01);
      chk("cinA.carryA", {31'h0, f3}, 32'h0);
      op("7f+01",  8'h7F, 8'h01, 2'd0, 0, 1, 1, 0, 0);
      chk("7f+01.const", {24'h0, bus, 6'b0, f1, f0}, {16'h0, 8'h80, 8'h03});
      op("cin1",   8'h05, 8'h05, 2'd2, 1, 1, 1, 0, 0);
      chk("cin1.const", {24'h0, bus, 7'b0, f4}, {16'h0, 8'h0B, 8'h01});
      op("cinL",   8'h00, 8'h00, 2'd3, 0, 1, 1, 0, 0);
      chk("cinL.const", {24'h0, bus}, 32'h01);
      op("noupd",  8'h10, 8'h20, 2'd0, 0, 1, 0, 0, 0);   // flags must hold
      op("upd_noiv", 8'hFF, 8'h01, 2'd0, 0, 0, 1, 0, 0); // ignored

      // Bus releases combinationally
      aa = 0; #1;
      chk("busZ.deassert", {24'h0, bus}, zexp);
      aa = 1;

      // Stack fill with 4 distinct flag sets
      op("set1", 8'h7F, 8'h01, 2'd0, 0, 1, 1, 0, 0);  op("push1", 0, 0, 0, 0, 0, 0, 1, 0);
      op("set2", 8'hFF, 8'h01, 2'd0, 0, 1, 1, 0, 0);  op("push2", 0, 0, 0, 0, 0, 0, 1, 0);
      op("set3", 8'h05, 8'h05, 2'd0, 1, 1, 1, 0, 0);  op("push3", 0, 0, 0, 0, 0, 0, 1, 0);
      op("set4", 8'h01, 8'h01, 2'd0, 0, 1, 1, 0, 0);  op("push4", 0, 0, 0, 0, 0, 0, 1, 0);
      chk("full.depth", {29'h0, sdep}, 32'd4);
      op("push5", 0, 0, 0, 0, 0, 0, 1, 0);
      chk("push5.ovf", {30'h0, sovf, sdep == 3'd4}, 32'h3);
      op("pop1", 0, 0, 0, 0, 0, 0, 0, 1);
      op("pop2", 0, 0, 0, 0, 0, 0, 0, 1);
      op("pop3", 0, 0, 0, 0, 0, 0, 0, 1);
      op("pop4", 0, 0, 0, 0, 0, 0, 0, 1);
      // First pushed set was Overflow|Sign
      chk("pop4.const", {27'h0, f4, f3, f2, f1, f0}, 32'h03);
      op("pop5", 0, 0, 0, 0, 0, 0, 0, 1);
      chk("pop5.unf", {31'h0, sunf}, 32'h1);

      // Simultaneous events from a clean state
      do_reset(); #1;
      op("pre",      8'h7F, 8'h01, 2'd0, 0, 1, 1, 0, 0);  // flags = 0x03
      op("push+upd", 8'hFF, 8'h01, 2'd0, 0, 1, 1, 1, 0);  // stack 0x03, flags 0x0C
      chk("push+upd.const", {27'h0, f4, f3, f2, f1, f0}, 32'h0C);
      op("pop+upd",  8'h05, 8'h05, 2'd0, 1, 1, 1, 0, 1);
      chk("pop+upd.const", {27'h0, f4, f3, f2, f1, f0}, 32'h03);
      op("pushA", 0, 0, 0, 0, 0, 0, 1, 0);
      op("pushB", 0, 0, 0, 0, 0, 0, 1, 0);
      op("push+pop", 0, 0, 0, 0, 0, 0, 1, 1);
      chk("push+pop.const", {29'h0, sdep}, 32'd1);
      op("b2b1", 8'hFF, 8'hFF, 2'd1, 0, 1, 1, 0, 0);
      op("b2b2", 8'h00, 8'h00, 2'd1, 0, 1, 1, 0, 0);  // chained carry -> 0x01
      chk("b2b2.const", {24'h0, bus}, 32'h01);

      // Asynchronous reset between edges clears at once
      #2 rst = 1; #1;
      chk("async.bus",   {24'h0, bus}, 32'h0);
      chk("async.state", {24'h0, f4, f3, f2, f1, f0, rv, sovf, sunf}, 32'h0);
      chk("async.depth", {29'h0, sdep}, 32'h0);
      // Capture attempted while reset held is aborted
      shf = 8'h12; lgc = 8'h34; iv = 1; uf = 1; push = 1;
      @(posedge clk); #1;
      chk("async.hold", {24'h0, bus}, 32'h0);
      idle_inputs();
      #2 rst = 0;
      model_reset();
      op("post", 8'h12, 8'h34, 2'd0, 0, 1, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
